// File: rtl/transport_rx_pkg.sv
// Shared definitions for the transport receiver: header codes, sample type, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package transport_rx_pkg;

    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;
    localparam logic [7:0] BROADCAST = 8'hFF;

    typedef logic [15:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CTRL_HI,
        CTRL_LO,
        AUD_HI,
        AUD_LO,
        PAD,
        DISCARD
    } state_t;

endpackage

// File: rtl/transport_rx_if.sv
// Byte-stream in, control/audio/status out bundle for transport_rx.
// Latency: n/a (wires only).
// Backpressure: none on the byte stream; audio is popped by the consumer via audioRd.
// Ports: byteIn/byteValid/myNum/audioRd driven by master; the rest driven by slave (the receiver).
interface transport_rx_if;
    import transport_rx_pkg::*;

    logic [7:0] byteIn;
    logic       byteValid;
    logic [7:0] myNum;
    logic [15:0] ctrlOut;
    logic       ctrlValid;
    sample_t    audioOut;
    logic       audioEmpty;
    logic       audioRd;
    logic [7:0] srcNum;
    logic       busy;
    logic       packetError;
    logic       overflow;

    modport master (
        output byteIn, byteValid, myNum, audioRd,
        input  ctrlOut, ctrlValid, audioOut, audioEmpty, srcNum, busy, packetError, overflow
    );

    modport slave (
        input  byteIn, byteValid, myNum, audioRd,
        output ctrlOut, ctrlValid, audioOut, audioEmpty, srcNum, busy, packetError, overflow
    );

endinterface

// File: rtl/transport_rx_fifo.sv
// First-word-fall-through sample FIFO with occupancy count and drop strobe.
// Latency: a push is visible at head_dat the cycle after it is written.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped and flagged.
// Ports: clk, reset (sync, high); push_vld/push_dat in; pop_req in; head_dat, empty, full, count, drop out.
module rx_sample_fifo
    import transport_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  sample_t                  push_dat,
    input  logic                     pop_req,
    output sample_t                  head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    sample_t        mem [DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign count = cnt_q;

    // A pop frees the slot in the same edge, so a full FIFO can still take a push.
    assign do_pop  = pop_req && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign drop    = push_vld && full && !do_pop;

    assign head_dat = empty ? '0 : mem[rd_q];

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/transport_rx.sv
// Packet receiver: parses header/source/payload bytes into control words and an audio sample FIFO.
// Latency: ctrlValid one cycle after the control low byte; a sample reaches the FIFO two cycles after its low byte.
// Backpressure: none on bytes; audio overflow drops samples and sets sticky overflow.
// Ports: clk, reset (sync, high), bus (transport_rx_if.slave).
// Optional: TRANSPORT_RX_FILTER_EN drops packets whose source is neither myNum nor broadcast.
module transport_rx
    import transport_rx_pkg::*;
#(
    parameter int PACKET_BYTES = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    transport_rx_if.slave bus
);
    localparam int CW = $clog2(PACKET_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(PACKET_BYTES - 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        is_ctrl_q, is_ctrl_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  src_q, src_d;
    logic [15:0] ctrl_q, ctrl_d;
    logic        ctrl_vld_q, ctrl_vld_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        push_q, push_d;
    sample_t     push_dat_q, push_dat_d;
    logic        overflow_q, overflow_d;

    logic        last_byte;
    logic        src_ok;
    logic        fifo_drop, fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

`ifdef TRANSPORT_RX_FILTER_EN
    assign src_ok = (bus.byteIn == bus.myNum) || (bus.byteIn == BROADCAST);
`else
    assign src_ok = 1'b1;
    logic unused_my_num;
    assign unused_my_num = ^bus.myNum;
`endif

    logic unused_fifo;
    assign unused_fifo = fifo_full ^ (^fifo_count);

    assign last_byte = (cnt_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_ctrl_d  = is_ctrl_q;
        hi_d       = hi_q;
        src_d      = src_q;
        ctrl_d     = ctrl_q;
        ctrl_vld_d = 1'b0;
        err_d      = 1'b0;
        push_d     = 1'b0;
        push_dat_d = push_dat_q;
        overflow_d = overflow_q | fifo_drop;

        if (bus.byteValid) begin
            cnt_d = last_byte ? '0 : cnt_q + CW'(1);
            unique case (state_q)
                IDLE: begin
                    if (bus.byteIn == HDR_CTRL) begin
                        state_d   = ADDR;
                        is_ctrl_d = 1'b1;
                    end else if (bus.byteIn == HDR_AUDIO) begin
                        state_d   = ADDR;
                        is_ctrl_d = 1'b0;
                    end else begin
                        state_d = DISCARD;
                        err_d   = 1'b1;
                    end
                end
                ADDR: begin
                    if (src_ok) begin
                        src_d   = bus.byteIn;
                        state_d = is_ctrl_q ? CTRL_HI : AUD_HI;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                CTRL_HI: begin
                    hi_d    = bus.byteIn;
                    state_d = CTRL_LO;
                end
                CTRL_LO: begin
                    ctrl_d     = {hi_q, bus.byteIn};
                    ctrl_vld_d = 1'b1;
                    state_d    = PAD;
                end
                AUD_HI: begin
                    hi_d    = bus.byteIn;
                    state_d = AUD_LO;
                end
                AUD_LO: begin
                    push_d     = 1'b1;
                    push_dat_d = {hi_q, bus.byteIn};
                    state_d    = AUD_HI;
                end
                default: ; // PAD / DISCARD wait for the final byte
            endcase
            // The final byte closes the packet regardless of what it carried.
            if (last_byte) begin
                state_d = IDLE;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_ctrl_q  <= 1'b0;
            hi_q       <= '0;
            src_q      <= '0;
            ctrl_q     <= '0;
            ctrl_vld_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            push_q     <= 1'b0;
            push_dat_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_ctrl_q  <= is_ctrl_d;
            hi_q       <= hi_d;
            src_q      <= src_d;
            ctrl_q     <= ctrl_d;
            ctrl_vld_q <= ctrl_vld_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            push_q     <= push_d;
            push_dat_q <= push_dat_d;
            overflow_q <= overflow_d;
        end
    end

    rx_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_q),
        .push_dat (push_dat_q),
        .pop_req  (bus.audioRd),
        .head_dat (bus.audioOut),
        .empty    (bus.audioEmpty),
        .full     (fifo_full),
        .count    (fifo_count),
        .drop     (fifo_drop)
    );

    assign bus.ctrlOut     = ctrl_q;
    assign bus.ctrlValid   = ctrl_vld_q;
    assign bus.srcNum      = src_q;
    assign bus.busy        = busy_q;
    assign bus.packetError = err_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_transport_rx.sv
// Testbench for transport_rx: directed packets plus randomized traffic against a packet-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_transport_rx;
    localparam int PB    = 16;
    localparam int DEPTH = 8;
    localparam int NS    = (PB - 2) / 2;
    localparam logic [7:0] MY = 8'h05;
`ifdef TRANSPORT_RX_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk;
    logic reset;
    transport_rx_if bus ();

    transport_rx #(.PACKET_BYTES(PB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0]  pkt [PB];
    logic [15:0] m_fifo [$];
    logic [23:0] exp_ctrl [$];
    logic [23:0] obs_ctrl [$];
    int          m_err;
    int          obs_err;
    logic        m_ovf;
    logic [7:0]  m_src;

    // Strobe capture, settled after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.ctrlValid === 1'b1) obs_ctrl.push_back({bus.ctrlOut, bus.srcNum});
        if (bus.packetError === 1'b1) obs_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] b, input logic v, input logic rd);
        bus.byteIn    = b;
        bus.byteValid = v;
        bus.audioRd   = rd;
        @(negedge clk);
    endtask

    function automatic bit accepted(input logic [7:0] src);
        return !FILT || (src == MY) || (src == 8'hFF);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        m_fifo.delete();
        exp_ctrl.delete();
        obs_ctrl.delete();
        m_err   = 0;
        obs_err = 0;
        m_ovf   = 1'b0;
        m_src   = 8'h00;
    endtask

    task automatic build_ctrl(input logic [7:0] src, input logic [15:0] w, input bit rnd_pad);
        pkt[0] = 8'h40;
        pkt[1] = src;
        pkt[2] = w[15:8];
        pkt[3] = w[7:0];
        for (int i = 4; i < PB; i++) pkt[i] = rnd_pad ? 8'($urandom) : 8'h00;
    endtask

    task automatic build_audio(input logic [7:0] src, input logic [15:0] base, input bit rnd);
        logic [15:0] s;
        pkt[0] = 8'h80;
        pkt[1] = src;
        for (int i = 0; i < NS; i++) begin
            s = rnd ? 16'($urandom) : base + 16'(i);
            pkt[2 + 2*i] = s[15:8];
            pkt[3 + 2*i] = s[7:0];
        end
    endtask

    // pop_after = k: pop in the cycle right after sample k's low byte (the cycle its push lands).
    task automatic send_pkt(input bit gaps, input int pop_after);
        bit hdr_ok, is_ctrl, is_aud, acc;
        int k;
        hdr_ok  = (pkt[0] == 8'h40) || (pkt[0] == 8'h80);
        is_ctrl = (pkt[0] == 8'h40);
        is_aud  = (pkt[0] == 8'h80);
        acc     = hdr_ok && accepted(pkt[1]);
        if (!hdr_ok) m_err++;
        if (acc) m_src = pkt[1];
        for (int idx = 0; idx < PB; idx++) begin
            cyc(pkt[idx], 1'b1, 1'b0);
            if (idx == 0 && hdr_ok) chk("busy_after_header", 32'(bus.busy), 32'd1);
            if (idx == 3 && acc && is_ctrl) begin
                chk("ctrl_strobe", 32'(bus.ctrlValid), 32'd1);
                chk("ctrl_word", 32'(bus.ctrlOut), 32'({pkt[2], pkt[3]}));
                exp_ctrl.push_back({pkt[2], pkt[3], pkt[1]});
            end
            k = -1;
            if (is_aud && idx >= 3 && (idx % 2) == 1) k = (idx - 3) / 2;
            if (k >= 0) begin
                if (k == pop_after) begin
                    cyc(8'($urandom), 1'b0, 1'b1);
                    if (m_fifo.size() > 0) void'(m_fifo.pop_front());
                end
                if (acc) begin
                    if (m_fifo.size() < DEPTH) m_fifo.push_back({pkt[idx-1], pkt[idx]});
                    else m_ovf = 1'b1;
                end
                if (k == pop_after) chk("overflow_at_pop_push", 32'(bus.overflow), 32'(m_ovf));
            end
            if (gaps && k != pop_after && ($urandom % 4) == 0)
                repeat ($urandom % 4) cyc(8'($urandom), 1'b0, 1'b0);
        end
        chk("busy_after_last", 32'(bus.busy), 32'd0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        chk("ctrl_count", 32'(obs_ctrl.size()), 32'(exp_ctrl.size()));
        while (obs_ctrl.size() > 0 && exp_ctrl.size() > 0)
            chk("ctrl_word_src", 32'(obs_ctrl.pop_front()), 32'(exp_ctrl.pop_front()));
        obs_ctrl.delete();
        exp_ctrl.delete();
        chk("src_num", 32'(bus.srcNum), 32'(m_src));
        chk("error_count", 32'(obs_err), 32'(m_err));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("audio_empty", 32'(bus.audioEmpty), 32'(m_fifo.size() == 0));
        if (m_fifo.size() > 0) chk("audio_head", 32'(bus.audioOut), 32'(m_fifo[0]));
    endtask

    task automatic drain();
        while (m_fifo.size() > 0) begin
            chk("drain_not_empty", 32'(bus.audioEmpty), 32'd0);
            chk("drain_sample", 32'(bus.audioOut), 32'(m_fifo[0]));
            cyc(8'($urandom), 1'b0, 1'b1);
            void'(m_fifo.pop_front());
        end
        chk("drain_empty", 32'(bus.audioEmpty), 32'd1);
        cyc(8'($urandom), 1'b0, 1'b1);
        chk("pop_on_empty", 32'(bus.audioEmpty), 32'd1);
    endtask

    initial begin
        int kind;
        int r;
        logic [7:0] src;
        reset         = 1'b1;
        bus.byteIn    = 8'h00;
        bus.byteValid = 1'b0;
        bus.audioRd   = 1'b0;
        bus.myNum     = MY;
        @(negedge clk);
        do_reset();

        chk("rst_ctrlOut", 32'(bus.ctrlOut), 32'h0);
        chk("rst_ctrlValid", 32'(bus.ctrlValid), 32'h0);
        chk("rst_audioEmpty", 32'(bus.audioEmpty), 32'h1);
        chk("rst_audioOut", 32'(bus.audioOut), 32'h0);
        chk("rst_srcNum", 32'(bus.srcNum), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_packetError", 32'(bus.packetError), 32'h0);
        chk("rst_overflow", 32'(bus.overflow), 32'h0);

        // Control packet 40 05 12 34 + zero padding.
        build_ctrl(8'h05, 16'h1234, 1'b0);
        send_pkt(1'b0, -1);
        chk("ctrl_direct_value", 32'(bus.ctrlOut), 32'h1234);
        chk("ctrl_direct_src", 32'(bus.srcNum), 32'h05);

        // Audio packet with samples 0001..0007.
        build_audio(8'h05, 16'h0001, 1'b0);
        send_pkt(1'b0, -1);
        chk("audio_direct_head", 32'(bus.audioOut), 32'h0001);
        drain();

        // Bad header with header-looking bytes inside, then a valid control packet.
        pkt[0] = 8'h33;
        for (int i = 1; i < PB; i++) pkt[i] = (i % 3 == 0) ? 8'h40 : 8'($urandom);
        send_pkt(1'b0, -1);
        build_ctrl(8'h05, 16'hA55A, 1'b1);
        send_pkt(1'b1, -1);
        chk("bad_hdr_one_error", 32'(obs_err), 32'd1);

        // Two audio packets without reads: FIFO fills and overflows.
        build_audio(8'h05, 16'h0100, 1'b0);
        send_pkt(1'b0, -1);
        build_audio(8'h05, 16'h0200, 1'b0);
        send_pkt(1'b0, -1);
        chk("two_audio_overflow", 32'(bus.overflow), 32'd1);
        chk("two_audio_first", 32'(bus.audioOut), 32'h0100);
        drain();

        // Reset in the middle of an audio packet.
        for (int i = 0; i < 7; i++) cyc((i == 0) ? 8'h80 : (i == 1) ? 8'h05 : ((i % 2) == 1) ? 8'(i / 2) : 8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        do_reset();
        chk("midrst_empty", 32'(bus.audioEmpty), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_src", 32'(bus.srcNum), 32'd0);
        build_ctrl(8'h05, 16'hBEEF, 1'b1);
        send_pkt(1'b0, -1);

        // Full FIFO: push and pop in the same cycle both succeed.
        build_audio(8'h05, 16'h0300, 1'b0);
        send_pkt(1'b0, -1);
        build_audio(8'h05, 16'h0400, 1'b0);
        send_pkt(1'b0, 1);
        drain();

        // Source filtering: foreign, broadcast, own number.
        build_ctrl(8'h09, 16'h0909, 1'b1);
        send_pkt(1'b0, -1);
        build_ctrl(8'hFF, 16'hFFFF, 1'b1);
        send_pkt(1'b0, -1);
        build_ctrl(8'h05, 16'h0505, 1'b1);
        send_pkt(1'b0, -1);
        build_audio(8'h09, 16'h0900, 1'b0);
        send_pkt(1'b0, -1);
        drain();

        // Randomized traffic with gaps, occasional reads and drains.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            kind = $urandom % 5;
            r    = $urandom % 3;
            src  = (r == 0) ? MY : (r == 1) ? 8'hFF : 8'($urandom);
            if (kind < 2) begin
                build_ctrl(src, 16'($urandom), 1'b1);
                send_pkt(1'b1, -1);
            end else if (kind < 4) begin
                build_audio(src, 16'h0000, 1'b1);
                send_pkt(1'b1, (($urandom % 4) == 0) ? int'($urandom % NS) : -1);
            end else begin
                for (int i = 0; i < PB; i++) pkt[i] = 8'($urandom);
                if (pkt[0] == 8'h40 || pkt[0] == 8'h80) pkt[0] = 8'h33;
                send_pkt(1'b1, -1);
            end
            if (($urandom % 3) == 0) drain();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
